// File: rtl/jtpang_objdma_if.sv
// Bus bundle between the object DMA engine and the CPU / RAM side.
interface jtpang_objdma_if #(
  parameter int unsigned AW = 12
) ();
  logic          dma_go;
  logic          busrq_n;
  logic          busak_n;
  logic [AW-1:0] dma_addr;
  logic          dma_rd;
  logic [7:0]    dma_din;
  logic [AW-1:0] obj_addr;
  logic [7:0]    obj_dout;
  logic          obj_we;
  logic          busy;

  modport master (
    input  dma_go, busak_n, dma_din,
    output busrq_n, dma_addr, dma_rd, obj_addr, obj_dout, obj_we, busy
  );

  modport slave (
    output dma_go, busak_n, dma_din,
    input  busrq_n, dma_addr, dma_rd, obj_addr, obj_dout, obj_we, busy
  );
endinterface

// File: rtl/jtpang_objdma.sv
// jtpang_objdma: requests the CPU bus, copies LEN bytes of object attributes from CPU work
// RAM into object RAM, then releases the bus.
module jtpang_objdma #(
  parameter int unsigned   AW     = 12,
  parameter logic [AW-1:0] SRC    = '0,
  parameter int unsigned   LEN    = 512,
  parameter int unsigned   RD_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  input logic             cen,
  jtpang_objdma_if.master bus
);

  localparam int unsigned LastI   = LEN - 1;
  localparam logic [AW:0] LastIdx = LastI[AW:0];
  localparam int unsigned LatI    = RD_LAT - 1;
  localparam logic [1:0]  LatLoad = LatI[1:0];

  typedef enum logic [2:0] {StIdle, StReq, StAddr, StWait, StWr, StRel} state_e;

  state_e        r_state, w_state_nxt;
  logic          r_go;
  logic          r_start, w_start_nxt;
  logic          r_busrq_n, w_busrq_n_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_rd, w_rd_nxt;
  logic          r_we, w_we_nxt;
  logic [AW:0]   r_idx, w_idx_nxt;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_dma_addr, w_dma_addr_nxt;
  logic [AW-1:0] r_obj_addr, w_obj_addr_nxt;
  logic [7:0]    r_obj_dout, w_obj_dout_nxt;

  logic          w_go_edge;
  logic          w_start;
  logic          w_grant;

  // The edge detector runs on every clk so short strobes are not missed between cen ticks.
  assign w_go_edge = bus.dma_go & ~r_go;
  assign w_start   = r_start | w_go_edge;
  assign w_grant   = ~bus.busak_n;

  // Next-state and output logic; everything holds unless cen is high.
  always_comb begin
    w_state_nxt    = r_state;
    w_start_nxt    = w_start;
    w_busrq_n_nxt  = r_busrq_n;
    w_busy_nxt     = r_busy;
    w_rd_nxt       = r_rd;
    w_we_nxt       = 1'b0;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_dma_addr_nxt = r_dma_addr;
    w_obj_addr_nxt = r_obj_addr;
    w_obj_dout_nxt = r_obj_dout;
    if (cen) begin
      // A pending start is consumed here, or dropped if the engine is not idle.
      w_start_nxt = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            w_state_nxt   = StReq;
            w_busrq_n_nxt = 1'b0;
            w_busy_nxt    = 1'b1;
            w_idx_nxt     = '0;
          end
        end
        StReq: begin
          if (w_grant) w_state_nxt = StAddr;
        end
        StAddr: begin
          if (!w_grant) begin
            w_rd_nxt = 1'b0;
          end else begin
            w_dma_addr_nxt = SRC + r_idx[AW-1:0];
            w_rd_nxt       = 1'b1;
            w_cnt_nxt      = LatLoad;
            w_state_nxt    = StWait;
          end
        end
        StWait: begin
          // Losing the grant restarts this byte from its address phase.
          if (!w_grant) begin
            w_rd_nxt    = 1'b0;
            w_state_nxt = StAddr;
          end else if (r_cnt == 2'd0) begin
            w_state_nxt = StWr;
          end else begin
            w_cnt_nxt = r_cnt - 2'd1;
          end
        end
        StWr: begin
          if (!w_grant) begin
            w_rd_nxt    = 1'b0;
            w_state_nxt = StAddr;
          end else begin
            w_obj_dout_nxt = bus.dma_din;
            w_obj_addr_nxt = r_idx[AW-1:0];
            w_we_nxt       = 1'b1;
            w_rd_nxt       = 1'b0;
            if (r_idx == LastIdx) begin
              w_busrq_n_nxt = 1'b1;
              w_state_nxt   = StRel;
            end else begin
              w_idx_nxt   = r_idx + 1'b1;
              w_state_nxt = StAddr;
            end
          end
        end
        StRel: begin
          if (bus.busak_n) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = StIdle;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // State and output registers; obj_we is cleared on the clk after it is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_go       <= 1'b0;
      r_start    <= 1'b0;
      r_busrq_n  <= 1'b1;
      r_busy     <= 1'b0;
      r_rd       <= 1'b0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_dma_addr <= SRC;
      r_obj_addr <= '0;
      r_obj_dout <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_go       <= bus.dma_go;
      r_start    <= w_start_nxt;
      r_busrq_n  <= w_busrq_n_nxt;
      r_busy     <= w_busy_nxt;
      r_rd       <= w_rd_nxt;
      r_we       <= w_we_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dma_addr <= w_dma_addr_nxt;
      r_obj_addr <= w_obj_addr_nxt;
      r_obj_dout <= w_obj_dout_nxt;
    end
  end

  assign bus.busrq_n  = r_busrq_n;
  assign bus.busy     = r_busy;
  assign bus.dma_rd   = r_rd;
  assign bus.dma_addr = r_dma_addr;
  assign bus.obj_we   = r_we;
  assign bus.obj_addr = r_obj_addr;
  assign bus.obj_dout = r_obj_dout;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: two instances (RD_LAT=1 from 0, RD_LAT=3 from FFE), a CPU grant
// model, a latency-accurate RAM model and a write scoreboard fed from a byte-copy model.
module tb_jtpang_objdma;

  localparam logic [11:0] SrcA = 12'h000;
  localparam logic [11:0] SrcB = 12'hFFE;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cen = 1'b0;
  logic cen_hold = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  jtpang_objdma_if #(.AW(12)) ifa ();
  jtpang_objdma_if #(.AW(12)) ifb ();

  jtpang_objdma #(.AW(12), .SRC(SrcA), .LEN(4), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(ifa.master)
  );
  jtpang_objdma #(.AW(12), .SRC(SrcB), .LEN(4), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(ifb.master)
  );

  // Random clock enable, forced low while cen_hold is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cen = cen_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // CPU work RAM with RD_LAT cen ticks of read latency; data is undefined unless dma_rd.
  logic [7:0] mem [4096];
  logic [7:0] pa, pb0, pb1, pb2;
  always @(posedge clk) begin
    if (cen) begin
      pa  <= ifa.dma_rd ? mem[ifa.dma_addr] : 8'hxx;
      pb0 <= ifb.dma_rd ? mem[ifb.dma_addr] : 8'hxx;
      pb1 <= pb0;
      pb2 <= pb1;
    end
  end
  assign ifa.dma_din = pa;
  assign ifb.dma_din = pb2;

  // CPU bus arbiter: grants gdly cen ticks after a request, force_* steals the bus back.
  int   gcnt_a = 0, gcnt_b = 0, gdly_a = 5, gdly_b = 3;
  logic gnt_n_a, gnt_n_b;
  logic force_a = 1'b0;
  always @(posedge clk) begin
    if (ifa.busrq_n) gcnt_a <= 0; else if (cen) gcnt_a <= gcnt_a + 1;
    if (ifb.busrq_n) gcnt_b <= 0; else if (cen) gcnt_b <= gcnt_b + 1;
  end
  initial begin
    gnt_n_a = 1'b1;
    gnt_n_b = 1'b1;
    forever begin
      @(negedge clk);
      gnt_n_a = !(!ifa.busrq_n && gcnt_a >= gdly_a);
      gnt_n_b = !(!ifb.busrq_n && gcnt_b >= gdly_b);
    end
  end
  assign ifa.busak_n = force_a | gnt_n_a;
  assign ifb.busak_n = gnt_n_b;

  // Monitors: object writes, read-strobe rises, busy falls, cen-tick timestamps.
  logic [19:0] wq_a[$], wq_b[$];
  logic [11:0] aq_b[$];
  int          tq_b[$];
  int          cen_cnt = 0, rdr_a = 0, bfall_a = 0;
  logic        prev_rd_a = 1'b0, prev_rd_b = 1'b0, prev_busy_a = 1'b0;
  logic        rq_last_a = 1'b0, rq_last_b = 1'b0;
  always @(posedge clk) if (cen) cen_cnt <= cen_cnt + 1;
  always @(negedge clk) begin
    if (ifa.obj_we) begin
      wq_a.push_back({ifa.obj_addr, ifa.obj_dout});
      if (ifa.obj_addr == 12'd3) rq_last_a = ifa.busrq_n;
    end
    if (ifa.dma_rd && !prev_rd_a) rdr_a++;
    if (!ifa.busy && prev_busy_a) bfall_a++;
    prev_rd_a   = ifa.dma_rd;
    prev_busy_a = ifa.busy;
    if (ifb.obj_we) begin
      wq_b.push_back({ifb.obj_addr, ifb.obj_dout});
      tq_b.push_back(cen_cnt);
      if (ifb.obj_addr == 12'd3) rq_last_b = ifb.busrq_n;
    end
    if (ifb.dma_rd && !prev_rd_b) aq_b.push_back(ifb.dma_addr);
    prev_rd_b = ifb.dma_rd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? ifb.busy : ifa.busy;
  endfunction

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    if (ramp) for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
  endtask

  task automatic pulse_go(input bit sel);
    @(negedge clk);
    if (sel) ifb.dma_go = 1'b1; else ifa.dma_go = 1'b1;
    @(negedge clk);
    ifa.dma_go = 1'b0;
    ifb.dma_go = 1'b0;
  endtask

  task automatic wait_busy(input bit sel, input logic v, input string tag);
    int n = 0;
    while (busy_of(sel) !== v && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, busy_of(sel), v);
  endtask

  task automatic wait_rdr(input int target, input string tag);
    int n = 0;
    while (rdr_a < target && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, rdr_a, target);
  endtask

  task automatic wait_cen(input int ticks);
    for (int k = 0; k < ticks; k++) begin
      int n = 0;
      do begin
        @(posedge clk);
        n++;
      end while (!cen && n < 1000);
    end
    @(negedge clk);
    #1;
  endtask

  // Expected writes: byte i of the transfer lands at object address i with RAM[src+i].
  task automatic check_xfer(input bit sel, input logic [11:0] src, input string tag);
    logic [19:0] q[$];
    logic [11:0] ea;
    if (sel) q = wq_b; else q = wq_a;
    check({tag, "_count"}, q.size(), 4);
    for (int i = 0; i < q.size(); i++) begin
      ea = src + 12'(i);
      check($sformatf("%s_byte%0d", tag, i), q[i], {12'(i), mem[ea]});
    end
    if (sel) wq_b.delete(); else wq_a.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    ifa.dma_go = 1'b0;
    ifb.dma_go = 1'b0;
    fill_mem(1'b1);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busrq_n", ifa.busrq_n, 1'b1);
    check("rst_busy", ifa.busy, 1'b0);
    check("rst_dma_rd", ifa.dma_rd, 1'b0);
    check("rst_obj_we", ifa.obj_we, 1'b0);
    check("rst_obj_addr", ifa.obj_addr, 12'h000);
    check("rst_obj_dout", ifa.obj_dout, 8'h00);
    check("rst_dma_addr_a", ifa.dma_addr, SrcA);
    check("rst_dma_addr_b", ifb.dma_addr, SrcB);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic copy of the A0.. ramp with a 5-tick grant delay.
    pulse_go(1'b0);
    wait_busy(1'b0, 1'b1, "x1_busy_rise");
    wait_busy(1'b0, 1'b0, "x1_busy_fall");
    check("x1_rq_after_last", rq_last_a, 1'b1);
    check("x1_busrq_idle", ifa.busrq_n, 1'b1);
    check_xfer(1'b0, SrcA, "x1");
    check("x1_busy_falls", bfall_a, 1);

    // A second strobe while busy is dropped.
    base = rdr_a;
    pulse_go(1'b0);
    wait_busy(1'b0, 1'b1, "x2_busy_rise");
    wait_rdr(base + 1, "x2_first_read");
    pulse_go(1'b0);
    wait_busy(1'b0, 1'b0, "x2_busy_fall");
    check_xfer(1'b0, SrcA, "x2");
    check("x2_busy_falls", bfall_a, 2);
    repeat (30) @(negedge clk);
    check("x2_not_queued_busy", ifa.busy, 1'b0);
    check("x2_not_queued_rq", ifa.busrq_n, 1'b1);
    check("x2_not_queued_we", wq_a.size(), 0);

    // A strobe after returning to idle starts a fresh transfer.
    pulse_go(1'b0);
    wait_busy(1'b0, 1'b1, "x3_busy_rise");
    wait_busy(1'b0, 1'b0, "x3_busy_fall");
    check_xfer(1'b0, SrcA, "x3");

    // Grant withdrawn while byte 2 waits for its read data.
    fill_mem(1'b0);
    base = rdr_a;
    pulse_go(1'b0);
    wait_rdr(base + 3, "loss_byte2_addr");
    force_a = 1'b1;
    wait_cen(10);
    check("loss_no_we", wq_a.size(), 2);
    check("loss_rq_held", ifa.busrq_n, 1'b0);
    check("loss_busy_held", ifa.busy, 1'b1);
    force_a = 1'b0;
    wait_busy(1'b0, 1'b0, "loss_busy_fall");
    check_xfer(1'b0, SrcA, "loss");

    // Random RAM contents and grant delays.
    for (int k = 0; k < 3; k++) begin
      fill_mem(1'b0);
      gdly_a = $urandom_range(0, 8);
      pulse_go(1'b0);
      wait_busy(1'b0, 1'b1, $sformatf("rnd%0d_busy_rise", k));
      wait_busy(1'b0, 1'b0, $sformatf("rnd%0d_busy_fall", k));
      check_xfer(1'b0, SrcA, $sformatf("rnd%0d", k));
    end

    // Reset asserted while byte 1 sits in its write state.
    base = rdr_a;
    pulse_go(1'b0);
    wait_rdr(base + 2, "rstx_byte1_addr");
    begin
      int n = 0;
      do begin
        @(posedge clk);
        n++;
      end while (!cen && n < 1000);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstx_busrq_n", ifa.busrq_n, 1'b1);
    check("rstx_obj_we", ifa.obj_we, 1'b0);
    check("rstx_busy", ifa.busy, 1'b0);
    check("rstx_dma_rd", ifa.dma_rd, 1'b0);
    check("rstx_writes_before", wq_a.size(), 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstx_no_more_writes", wq_a.size(), 1);
    check("rstx_still_idle", ifa.busy, 1'b0);
    wq_a.delete();
    pulse_go(1'b0);
    wait_busy(1'b0, 1'b1, "rstx_restart_rise");
    wait_busy(1'b0, 1'b0, "rstx_restart_fall");
    check_xfer(1'b0, SrcA, "rstx_restart");

    // Start strobe while cen is held low is kept and honoured on the first cen.
    cen_hold = 1'b1;
    repeat (3) @(negedge clk);
    pulse_go(1'b0);
    repeat (20) @(negedge clk);
    check("cenlow_busy", ifa.busy, 1'b0);
    check("cenlow_busrq_n", ifa.busrq_n, 1'b1);
    cen_hold = 1'b0;
    begin
      int n = 0;
      do begin
        @(posedge clk);
        n++;
      end while (!cen && n < 1000);
    end
    #2;
    check("cenlow_first_busy", ifa.busy, 1'b1);
    check("cenlow_first_busrq_n", ifa.busrq_n, 1'b0);
    wait_busy(1'b0, 1'b0, "cenlow_busy_fall");
    check_xfer(1'b0, SrcA, "cenlow");

    // RD_LAT=3 instance: wrapped source addresses and RD_LAT+2 cen ticks per byte.
    fill_mem(1'b0);
    pulse_go(1'b1);
    wait_busy(1'b1, 1'b1, "b_busy_rise");
    wait_busy(1'b1, 1'b0, "b_busy_fall");
    check("b_rq_after_last", rq_last_b, 1'b1);
    check("b_addr_count", aq_b.size(), 4);
    for (int i = 0; i < aq_b.size(); i++) begin
      logic [11:0] ea;
      ea = SrcB + 12'(i);
      check($sformatf("b_addr%0d", i), aq_b[i], ea);
    end
    check("b_we_count", tq_b.size(), 4);
    for (int i = 1; i < tq_b.size(); i++) begin
      check($sformatf("b_spacing%0d", i), tq_b[i] - tq_b[i-1], 5);
    end
    check_xfer(1'b1, SrcB, "b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
